ahb_arbiter_param: RTL and testbench



---
 rtl/ahb_arbiter_param.sv | 154 +++++++++++++++
 tb/tb_ahb_arbiter_param.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_param.sv
// ----------------------------------------------------------------------------
// ahb_arbiter_param
//
// AHB bus arbiter for NUM_MASTERS masters. Chooses the next bus owner with
// either fixed priority (lowest index wins) or rotating priority, honours
// locked transfers, and masks masters that received a SPLIT response until
// the slave releases them through HSPLIT.
//
// Handshake: HREADY=1 on a rising HCLK edge completes the current data phase.
// Only on such an edge may the grant move and the address phase owner
// (HMASTER/HMASTLOCK) advance. With HREADY=0 grant, owner and priority
// pointer all hold. SPLIT masking is sampled on HREADY=0 edges, when the slave
// drives the first cycle of its two-cycle SPLIT response.
//
// Ports:
//   HCLK        bus clock, all state on rising edge
//   HRESETn     asynchronous active-low reset
//   HBUSREQx    bus request per master
//   HLOCKx      locked-transfer request per master
//   HGRANTx     one-hot grant, registered
//   HSPLIT      split-release pulses from slaves
//   HREADY      transfer-complete from the selected slave
//   HRESP       response from the selected slave (2'b11 = SPLIT)
//   HMASTER     index of the address-phase owner, registered
//   HMASTLOCK   current address phase is locked, registered
//   split_mask  masters currently masked by SPLIT (debug state)
// ----------------------------------------------------------------------------
module ahb_arbiter_param #(
  parameter int NUM_MASTERS    = 16,
  parameter int MASTER_W       = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [MASTER_W-1:0]    HMASTER,
  output logic                   HMASTLOCK,
  output logic [NUM_MASTERS-1:0] split_mask
);

  localparam logic [NUM_MASTERS-1:0] DEF_ONEHOT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MASTER_W-1:0]    DEF_IDX    = MASTER_W'(DEFAULT_MASTER);

  logic [MASTER_W-1:0]    rr_ptr;
  logic [NUM_MASTERS-1:0] eligible;

  // Attributes of the currently granted master, decoded from the one-hot
  // grant so no variable-width indexing is needed.
  logic [MASTER_W-1:0]    g_idx;
  logic                   g_lock;
  logic                   g_req;
  logic                   g_masked;
  logic                   hold;

  // Arbitration result.
  logic                   found;
  logic [MASTER_W-1:0]    win_idx;
  logic [NUM_MASTERS-1:0] win_vec;
  int                     cand;

  // Split mask update.
  logic [NUM_MASTERS-1:0] split_set;
  logic [NUM_MASTERS-1:0] split_next;

  assign eligible = HBUSREQx & ~split_mask;

  always_comb begin
    g_idx    = DEF_IDX;
    g_lock   = 1'b0;
    g_req    = 1'b0;
    g_masked = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANTx[i]) begin
        g_idx    = MASTER_W'(i);
        g_lock   = HLOCKx[i];
        g_req    = HBUSREQx[i];
        g_masked = split_mask[i];
      end
    end
  end

  // A masked owner loses its lock so the next HREADY edge re-arbitrates.
  assign hold = g_lock & g_req & ~g_masked;

  always_comb begin
    found   = 1'b0;
    win_idx = DEF_IDX;
    win_vec = DEF_ONEHOT;
    cand    = 0;
    if (ROUND_ROBIN != 0) begin
      // Search starts just above the last winner; the last winner itself
      // is visited last (offset NUM_MASTERS wraps back to rr_ptr).
      for (int off = 1; off <= NUM_MASTERS; off++) begin
        cand = (int'(rr_ptr) + off) % NUM_MASTERS;
        if (!found && eligible[cand]) begin
          found   = 1'b1;
          win_idx = MASTER_W'(cand);
          win_vec = NUM_MASTERS'(1) << cand;
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && eligible[i]) begin
          found   = 1'b1;
          win_idx = MASTER_W'(i);
          win_vec = NUM_MASTERS'(1) << i;
        end
      end
    end
  end

  always_comb begin
    split_set = '0;
    if (!HREADY && (HRESP == 2'b11)) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (HMASTER == MASTER_W'(i)) split_set[i] = 1'b1;
      end
    end
    // The default master must always stay grantable.
    split_set[DEFAULT_MASTER] = 1'b0;
    // A release in the same cycle as a new SPLIT wins.
    split_next = (split_mask | split_set) & ~HSPLIT;
    split_next[DEFAULT_MASTER] = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HGRANTx    <= DEF_ONEHOT;
      HMASTER    <= DEF_IDX;
      HMASTLOCK  <= 1'b0;
      split_mask <= '0;
      rr_ptr     <= DEF_IDX;
    end else begin
      split_mask <= split_next;
      if (HREADY) begin
        // One-cycle AHB handover: owner follows the grant of this cycle.
        HMASTER   <= g_idx;
        HMASTLOCK <= g_lock;
        if (!hold) begin
          HGRANTx <= win_vec;
          // A default fallback leaves the rotation point unchanged.
          if (found) rr_ptr <= win_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// ----------------------------------------------------------------------------
// tb_ahb_arbiter_param
//
// Bench for ahb_arbiter_param. Two instances share all inputs: dut runs
// rotating priority, dut_fx fixed priority. Expected output tuples
// {HGRANTx, HMASTER, HMASTLOCK, split_mask} are pushed to exp_q as stimulus
// is applied and popped against the outputs sampled 1 ns after each edge.
// ----------------------------------------------------------------------------
module tb_ahb_arbiter_param;

  localparam int N  = 16;
  localparam int MW = 4;
  localparam int EW = N + MW + 1 + N;

  logic          HCLK;
  logic          HRESETn;
  logic [N-1:0]  HBUSREQx;
  logic [N-1:0]  HLOCKx;
  logic [N-1:0]  HSPLIT;
  logic          HREADY;
  logic [1:0]    HRESP;

  logic [N-1:0]  HGRANTx,    fx_HGRANTx;
  logic [MW-1:0] HMASTER,    fx_HMASTER;
  logic          HMASTLOCK,  fx_HMASTLOCK;
  logic [N-1:0]  split_mask, fx_split_mask;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  ahb_arbiter_param #(
    .NUM_MASTERS(N), .MASTER_W(MW), .DEFAULT_MASTER(0), .ROUND_ROBIN(1)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HGRANTx(HGRANTx), .HSPLIT(HSPLIT), .HREADY(HREADY), .HRESP(HRESP),
    .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK), .split_mask(split_mask)
  );

  ahb_arbiter_param #(
    .NUM_MASTERS(N), .MASTER_W(MW), .DEFAULT_MASTER(0), .ROUND_ROBIN(0)
  ) dut_fx (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx),
    .HGRANTx(fx_HGRANTx), .HSPLIT(HSPLIT), .HREADY(HREADY), .HRESP(HRESP),
    .HMASTER(fx_HMASTER), .HMASTLOCK(fx_HMASTLOCK), .split_mask(fx_split_mask)
  );

  // Clock / reset block
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Grant must be one-hot on every cycle for both instances.
  always @(negedge HCLK) begin
    checks++;
    if ($onehot(HGRANTx) !== 1'b1) begin
      errors++;
      $display("FAIL onehot_rr t=%0t got %h required one-hot", $time, HGRANTx);
    end
    checks++;
    if ($onehot(fx_HGRANTx) !== 1'b1) begin
      errors++;
      $display("FAIL onehot_fx t=%0t got %h required one-hot", $time, fx_HGRANTx);
    end
  end

  function automatic logic [EW-1:0] mk(int gi, int m, logic l, logic [N-1:0] msk);
    logic [N-1:0] g;
    g = N'(1) << gi;
    return {g, MW'(m), l, msk};
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HBUSREQx = '0;
    HLOCKx   = '0;
    HSPLIT   = '0;
    HREADY   = 1'b1;
    HRESP    = 2'b00;
  endtask

  task automatic do_reset();
    idle_inputs();
    HRESETn = 1'b0;
    step();
    step();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    logic [EW-1:0] e;
    idle_inputs();
    HRESETn = 1'b0;
    #1;
    step();
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    e = exp_q.pop_front();
    checks++;
    if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
      errors++;
      $display("FAIL reset_rr got %h required %h", {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
    end
    e = exp_q.pop_front();
    checks++;
    if ({fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask} !== e) begin
      errors++;
      $display("FAIL reset_fx got %h required %h", {fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask}, e);
    end
    step();
    HRESETn = 1'b1;
    // SPLIT while the default master owns the bus must not mask it.
    HREADY = 1'b0;
    HRESP  = 2'b11;
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    step();
    e = exp_q.pop_front();
    checks++;
    if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
      errors++;
      $display("FAIL split_default got %h required %h", {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
    end
    idle_inputs();
  endtask

  task automatic test_rr_rotate();
    logic [EW-1:0] e;
    do_reset();
    HBUSREQx = 16'h000E;
    exp_q.push_back(mk(1, 0, 1'b0, '0));
    exp_q.push_back(mk(2, 1, 1'b0, '0));
    exp_q.push_back(mk(3, 2, 1'b0, '0));
    exp_q.push_back(mk(1, 3, 1'b0, '0));
    exp_q.push_back(mk(2, 1, 1'b0, '0));
    exp_q.push_back(mk(3, 2, 1'b0, '0));
    for (int n = 0; n < 6; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL rr_rotate step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
    // No requests: fall back to the default master.
    HBUSREQx = '0;
    exp_q.push_back(mk(0, 3, 1'b0, '0));
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    for (int n = 0; n < 2; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL rr_default step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
  endtask

  task automatic test_fixed();
    logic [EW-1:0] e;
    do_reset();
    HBUSREQx = 16'h0018;
    exp_q.push_back(mk(3, 0, 1'b0, '0));
    for (int n = 0; n < 3; n++) exp_q.push_back(mk(3, 3, 1'b0, '0));
    for (int n = 0; n < 4; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask} !== e) begin
        errors++;
        $display("FAIL fixed_prio step %0d got %h required %h", n, {fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask}, e);
      end
    end
    HBUSREQx = 16'h0010;
    exp_q.push_back(mk(4, 3, 1'b0, '0));
    exp_q.push_back(mk(4, 4, 1'b0, '0));
    for (int n = 0; n < 2; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask} !== e) begin
        errors++;
        $display("FAIL fixed_drop step %0d got %h required %h", n, {fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask}, e);
      end
    end
  endtask

  task automatic test_lock();
    logic [EW-1:0] e;
    do_reset();
    HBUSREQx = 16'h0006;
    HLOCKx   = 16'h0004;
    exp_q.push_back(mk(1, 0, 1'b0, '0));
    exp_q.push_back(mk(2, 1, 1'b0, '0));
    exp_q.push_back(mk(2, 2, 1'b1, '0));
    exp_q.push_back(mk(2, 2, 1'b1, '0));
    exp_q.push_back(mk(2, 2, 1'b1, '0));
    for (int n = 0; n < 5; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL lock_hold step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
    HLOCKx = '0;
    exp_q.push_back(mk(1, 2, 1'b0, '0));
    exp_q.push_back(mk(2, 1, 1'b0, '0));
    for (int n = 0; n < 2; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL lock_release step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
  endtask

  task automatic test_split();
    logic [EW-1:0] e;
    do_reset();
    HBUSREQx = 16'h0020;
    exp_q.push_back(mk(5, 0, 1'b0, '0));
    exp_q.push_back(mk(5, 5, 1'b0, '0));
    // SPLIT response from the slave while master 5 owns the bus.
    exp_q.push_back(mk(5, 5, 1'b0, 16'h0020));
    // Master 5 masked, master 3 takes over.
    exp_q.push_back(mk(3, 5, 1'b0, 16'h0020));
    exp_q.push_back(mk(3, 3, 1'b0, 16'h0020));
    exp_q.push_back(mk(3, 3, 1'b0, 16'h0020));
    // Release, then master 5 at its rotating turn.
    exp_q.push_back(mk(3, 3, 1'b0, '0));
    exp_q.push_back(mk(5, 3, 1'b0, '0));
    exp_q.push_back(mk(3, 5, 1'b0, '0));
    // SPLIT and release in the same cycle: release wins.
    exp_q.push_back(mk(3, 5, 1'b0, '0));
    for (int n = 0; n < 10; n++) begin
      case (n)
        2:       begin HREADY = 1'b0; HRESP = 2'b11; end
        3:       begin HREADY = 1'b1; HRESP = 2'b00; HBUSREQx = 16'h0028; end
        6:       HSPLIT = 16'h0020;
        7:       HSPLIT = '0;
        9:       begin HREADY = 1'b0; HRESP = 2'b11; HSPLIT = 16'h0020; end
        default: ;
      endcase
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL split step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
    idle_inputs();
  endtask

  task automatic test_hold_reset();
    logic [EW-1:0] e;
    do_reset();
    HBUSREQx = 16'h0004;
    exp_q.push_back(mk(2, 0, 1'b0, '0));
    exp_q.push_back(mk(2, 2, 1'b0, '0));
    for (int n = 0; n < 2; n++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL hold_setup step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
    HREADY = 1'b0;
    for (int n = 0; n < 4; n++) begin
      HBUSREQx = N'($urandom_range(1, 16'hFFFF));
      HLOCKx   = N'($urandom_range(0, 16'hFFFF));
      exp_q.push_back(mk(2, 2, 1'b0, '0));
      step();
      e = exp_q.pop_front();
      checks++;
      if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
        errors++;
        $display("FAIL hready_freeze step %0d got %h required %h", n, {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
      end
    end
    // Asynchronous reset mid-hold, checked before the next edge.
    HRESETn = 1'b0;
    #2;
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    e = exp_q.pop_front();
    checks++;
    if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
      errors++;
      $display("FAIL async_reset_rr got %h required %h", {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
    end
    e = exp_q.pop_front();
    checks++;
    if ({fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask} !== e) begin
      errors++;
      $display("FAIL async_reset_fx got %h required %h", {fx_HGRANTx, fx_HMASTER, fx_HMASTLOCK, fx_split_mask}, e);
    end
    #1;
    HRESETn = 1'b1;
    idle_inputs();
    exp_q.push_back(mk(0, 0, 1'b0, '0));
    step();
    e = exp_q.pop_front();
    checks++;
    if ({HGRANTx, HMASTER, HMASTLOCK, split_mask} !== e) begin
      errors++;
      $display("FAIL post_reset_idle got %h required %h", {HGRANTx, HMASTER, HMASTLOCK, split_mask}, e);
    end
  endtask

  initial begin
    test_reset();
    test_rr_rotate();
    test_fixed();
    test_lock();
    test_split();
    test_hold_reset();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
